// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM read/write traffic generator and checker.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    SETTLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int IDX_W     = 16;
  localparam int ERR_CNT_W = 16;

  // Pattern word k is k+1, so the first word written is never zero.
  function automatic logic [IDX_W:0] pattern_word(input logic [IDX_W-1:0] k);
    return (IDX_W+1)'(k) + (IDX_W+1)'(1);
  endfunction

endpackage

// File: rtl/sdram_rw_test_if.sv
// User-side write/read port of the SDRAM FIFO plus the test status outputs.
interface sdram_rw_test_if #(
  parameter int DATA_W = 16
) ();

  logic                                  init_done;
  logic                                  wr_en;
  logic [DATA_W-1:0]                     wr_data;
  logic                                  wr_load;
  logic                                  rd_en;
  logic [DATA_W-1:0]                     rd_data;
  logic                                  rd_load;
  logic                                  sdram_read_valid;
  logic                                  test_done;
  logic                                  test_err;
  logic [sdram_test_pkg::ERR_CNT_W-1:0]  err_cnt;

  modport master (
    input  init_done, rd_data,
    output wr_en, wr_data, wr_load, rd_en, rd_load, sdram_read_valid,
           test_done, test_err, err_cnt
  );

  modport slave (
    output init_done, rd_data,
    input  wr_en, wr_data, wr_load, rd_en, rd_load, sdram_read_valid,
           test_done, test_err, err_cnt
  );

endinterface

// File: rtl/sdram_test_chk.sv
// Read-data checker: delays expected data by the read latency, compares, and keeps
// a sticky error flag plus a saturating mismatch counter.
module sdram_test_chk
  import sdram_test_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 rd_en_i,
  input  logic [DATA_W-1:0]    exp_i,
  input  logic [DATA_W-1:0]    rd_data_i,
  output logic                 test_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  logic [DATA_W-1:0]    exp_q [RD_LAT];
  logic [RD_LAT-1:0]    vld_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic                 mismatch;

  assign mismatch = vld_q[RD_LAT-1] && (rd_data_i != exp_q[RD_LAT-1]);

  // NOTE: the expected-data delay line has no reset; the reset valid bits gate every use.
  always_ff @(posedge clk) begin
    exp_q[0] <= exp_i;
    for (int i = 1; i < RD_LAT; i++) exp_q[i] <= exp_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      vld_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= rd_en_i;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      if (mismatch) begin
        err_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign test_err_o = err_q;
  assign err_cnt_o  = cnt_q;

endmodule

// File: rtl/sdram_rw_test.sv
// Traffic generator: writes an incrementing pattern through the SDRAM FIFO, waits for
// it to drain, reads it back and hands the returned data to the checker.
module sdram_rw_test
  import sdram_test_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_WORDS  = 1024,
  parameter int SETTLE_CYC = 64,
  parameter int RD_LAT     = 1
) (
  input logic             clk,
  input logic             rst,
  sdram_rw_test_if.master sdram
);

  localparam logic [IDX_W-1:0] LAST_WORD   = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SETTLE = IDX_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_DRAIN  = IDX_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en, rd_en, load, read_valid, done;

  assign pat = DATA_W'(pattern_word(idx_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wr_data_d  = wr_data_q;
    wr_data    = wr_data_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    load       = 1'b0;
    read_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: if (sdram.init_done) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        wr_data   = pat;
        wr_data_d = pat;
        if (idx_q == LAST_WORD) begin
          idx_d   = '0;
          state_d = SETTLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == LAST_SETTLE) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      READ: begin
        rd_en      = 1'b1;
        read_valid = 1'b1;
        if (idx_q == LAST_WORD) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        read_valid = 1'b1;
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE:    done = 1'b1;
      default: state_d = IDLE;
    endcase
    // Losing init_done aborts the pass; outputs drop on the following cycle.
    if (state_q != IDLE && !sdram.init_done) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  assign sdram.wr_en            = wr_en;
  assign sdram.wr_data          = wr_data;
  assign sdram.wr_load          = load;
  assign sdram.rd_en            = rd_en;
  assign sdram.rd_load          = load;
  assign sdram.sdram_read_valid = read_valid;
  assign sdram.test_done        = done;

  sdram_test_chk #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (load),
    .rd_en_i    (rd_en),
    .exp_i      (pat),
    .rd_data_i  (sdram.rd_data),
    .test_err_o (sdram.test_err),
    .err_cnt_o  (sdram.err_cnt)
  );

endmodule
